dcache_ctrl: RTL
================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-through data cache and controller for the MEM stage.
//  Consumes the EX/MEM pipeline outputs: MemRead/MemWrite, ALU address, store data.
//  Produces `hit`, which the pipeline registers use as their advance enable
//  (hit=0 stalls the pipeline). Refills lines over a word-wide req/ack backing-memory port.
// PARAMETERS
//  LINES          16  number of cache lines, power of 2
//  WORDS_PER_LINE 4   32-bit words per line, power of 2, >=2
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  memread    in   1   load request (Mout read bit); held stable while hit=0
//  memwrite   in   1   store request (Mout write bit); held stable while hit=0
//  addr       in   32  byte address (aluout); bits[1:0] ignored
//  wdata      in   32  store data (readdat2out)
//  rdata      out  32  load data, valid when hit=1 and memread=1
//  hit        out  1   1 = access complete or no access; pipeline may advance
//  mem_req    out  1   backing-memory request
//  mem_we     out  1   1 = memory write, 0 = memory read
//  mem_addr   out  32  word-aligned memory byte address
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data, valid with mem_ack
//  mem_ack    in   1   one-cycle completion pulse per word
// BEHAVIOUR
//  Address split (low to high): 2 byte bits | OFS = log2(WORDS_PER_LINE) |
//   IDX = log2(LINES) | tag = remaining bits. Storage: valid[LINES], tag array,
//   data array. Data and tag are read combinationally.
//  Reset (rst=0, any time): state=IDLE, all valid=0, beat counter=0, mem_req=0,
//   mem_we=0, mem_addr=0, mem_wdata=0. rdata is a combinational output.
//   An in-flight fill is aborted and the line stays invalid.
//  State IDLE:
//   - No access (memread=memwrite=0): hit=1.
//   - Read hit (valid[idx] and tag match): hit=1, rdata=data[idx][ofs] in the same
//     cycle; zero stall.
//   - Read miss: hit=0. Next state FILL; clear valid[idx]; latch tag/idx; counter=0.
//   - Write (hit or miss): hit=0. Next state WRITE; mem_req=1, mem_we=1,
//     mem_addr={addr[31:2],2'b00}, mem_wdata=wdata.
//   - memread=memwrite=1: treated as a write.
//  State FILL (hit=0):
//   - mem_req=1, mem_we=0, mem_addr = line base + 4*counter.
//   - On each mem_ack: store mem_rdata at data[idx][counter], counter++.
//   - On the ack with counter=WORDS_PER_LINE-1: set tag and valid[idx]; go to IDLE;
//     counter wraps to 0. The held request then read-hits the following cycle.
//   - Miss penalty = sum of ack latencies + 1 cycle.
//  State WRITE (hit=0):
//   - Hold mem_req/mem_we/mem_addr/mem_wdata until mem_ack.
//   - On mem_ack: if valid[idx] and tag match, update data[idx][ofs]
//     (no allocate on miss). Go to WDONE; mem_req=0.
//  State WDONE: hit=1 for exactly one cycle; go to IDLE.
//  mem_req deasserts in the cycle after the final ack. mem_ack while mem_req=0 is ignored.
//  Inputs are sampled only in IDLE; their changes during FILL/WRITE are ignored.
// TESTING
//  1. Reset, then read 0x100 (miss), ack each beat after 2 cycles -> 4 reads at
//     0x100,104,108,10C, hit=0 throughout, then hit=1 with rdata=word@0x100.
//  2. After test 1, read 0x108 -> hit=1 in the same cycle, rdata=fill word 2,
//     mem_req stays 0.
//  3. Write 0xDEADBEEF to 0x104 (line resident) -> one mem write, WDONE hit pulse;
//     then read 0x104 hits with 0xDEADBEEF.
//  4. Write to a non-resident line 0x2000 -> memory written, no fill; a following
//     read of 0x2000 misses.
//  5. Read to 0x100+LINES*16 (same idx, new tag) -> refill evicts the old line;
//     a re-read of 0x100 misses.
//  6. Assert rst=0 after beat 2 of a fill -> mem_req=0 immediately, line invalid;
//     the retried read misses and refills all 4 beats.

Source files
------------

// File: rtl/dcache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-through, no-write-allocate data cache
//                and controller for the MEM stage. `hit` is the pipeline
//                advance enable; misses refill a whole line one word at a
//                time over a req/ack backing-memory port.
//  Ports       : clk, rst (async, active-low)
//                memread, memwrite, addr, wdata  - EX/MEM request
//                rdata, hit                      - load data / advance enable
//                mem_req, mem_we, mem_addr,
//                mem_wdata, mem_rdata, mem_ack   - backing-memory port
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OFS_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFS_W - IDX_W;

  localparam logic [OFS_W-1:0] c_cnt_one  = OFS_W'(1);
  localparam logic [OFS_W-1:0] c_cnt_last = OFS_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_WDONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [OFS_W-1:0]  cnt_q, cnt_d;
  logic [29:0]       line_q, line_d;     // word address [31:2] of the access being serviced
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][WORDS_PER_LINE];

  // Array write port controls
  logic              w_data_we;
  logic [IDX_W-1:0]  w_data_idx;
  logic [OFS_W-1:0]  w_data_ofs;
  logic [31:0]       w_data_val;
  logic              w_tag_we;

  // Lookup fields of the incoming request
  logic [OFS_W-1:0]  w_a_ofs;
  logic [IDX_W-1:0]  w_a_idx;
  logic [TAG_W-1:0]  w_a_tag;
  logic              w_lookup_hit;

  // Fields of the latched request
  logic [OFS_W-1:0]  w_l_ofs;
  logic [IDX_W-1:0]  w_l_idx;
  logic [TAG_W-1:0]  w_l_tag;
  logic              w_ack;
  logic              w_unused;

  assign w_a_ofs = addr[2 +: OFS_W];
  assign w_a_idx = addr[2 + OFS_W +: IDX_W];
  assign w_a_tag = addr[31 -: TAG_W];
  assign w_l_ofs = line_q[0 +: OFS_W];
  assign w_l_idx = line_q[OFS_W +: IDX_W];
  assign w_l_tag = line_q[29 -: TAG_W];

  assign w_lookup_hit = valid_q[w_a_idx] && (tag_q[w_a_idx] == w_a_tag);
  assign rdata        = data_q[w_a_idx][w_a_ofs];

  // A stray ack with no outstanding request is dropped
  assign w_ack    = mem_ack && mem_req_q;
  assign w_unused = ^addr[1:0];

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit         = 1'b0;
    w_data_we   = 1'b0;
    w_data_idx  = w_l_idx;
    w_data_ofs  = w_l_ofs;
    w_data_val  = mem_rdata;
    w_tag_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (memwrite) begin
          // Write-through: every store goes to memory, hit or miss
          state_d     = S_WRITE;
          line_d      = addr[31:2];
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = wdata;
        end else if (memread) begin
          if (w_lookup_hit) begin
            hit = 1'b1;
          end else begin
            // Invalidate first so an aborted fill leaves no stale line
            state_d          = S_FILL;
            valid_d[w_a_idx] = 1'b0;
            line_d           = addr[31:2];
            cnt_d            = '0;
            mem_req_d        = 1'b1;
            mem_we_d         = 1'b0;
            mem_addr_d       = {addr[31:2+OFS_W], {OFS_W{1'b0}}, 2'b00};
          end
        end else begin
          hit = 1'b1;
        end
      end

      S_FILL: begin
        if (w_ack) begin
          w_data_we  = 1'b1;
          w_data_ofs = cnt_q;
          w_data_val = mem_rdata;
          cnt_d      = cnt_q + c_cnt_one;
          if (cnt_q == c_cnt_last) begin
            w_tag_we         = 1'b1;
            valid_d[w_l_idx] = 1'b1;
            mem_req_d        = 1'b0;
            state_d          = S_IDLE;
          end else begin
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end
      end

      S_WRITE: begin
        if (w_ack) begin
          // No allocate: only a resident line is updated
          if (valid_q[w_l_idx] && (tag_q[w_l_idx] == w_l_tag)) begin
            w_data_we  = 1'b1;
            w_data_ofs = w_l_ofs;
            w_data_val = mem_wdata_q;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_WDONE;
        end
      end

      S_WDONE: begin
        hit     = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Storage arrays carry no reset; the valid bits qualify their contents
  always_ff @(posedge clk) begin
    if (w_data_we) begin
      data_q[w_data_idx][w_data_ofs] <= w_data_val;
    end
    if (w_tag_we) begin
      tag_q[w_l_idx] <= w_l_tag;
    end
  end

endmodule
`default_nettype wire
